// File: rtl/cpu_pkg.sv
// Shared definitions for the datapath memory-side blocks.
//   mem_state_t : handshake FSM states (IDLE, REQ, DONE)
//   ADDR_W_DEF  : default memory address width
//   DATA_W_DEF  : default datapath / memory data width
package cpu_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_handshake_fsm.sv
// Memory handshake controller: runs one read or write transaction at a time.
// Optional macro: MEM_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES cycles in REQ without ack.
// Ports:
//   clock, clear : rising-edge clock, asynchronous active-low reset
//   read, write  : start requests, only honoured in IDLE (read wins over write)
//   mem_ack      : memory completion, only meaningful in REQ
//   mem_req      : request, high for every REQ cycle
//   mem_we       : 1 = write, 0 = read; held for the whole REQ phase
//   busy         : high in REQ and DONE
//   done         : one-cycle pulse in DONE
//   err          : one-cycle pulse after a timeout abort (0 without MEM_TIMEOUT_EN)
//   idle         : FSM is in IDLE (gates MAR/MDR loads in the parent)
//   rd_capture   : MDR should take mem_rdata at this edge
module mem_handshake_fsm
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic clear,
  input  logic read,
  input  logic write,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_we,
  output logic busy,
  output logic done,
  output logic err,
  output logic idle,
  output logic rd_capture
);

  mem_state_t state_r;
  mem_state_t state_nxt_s;
  logic       we_r;
  logic       we_nxt_s;
  logic       req_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;
  logic       err_nxt_s;
  logic       timeout_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;

  // Counts REQ cycles without ack; restarts whenever the FSM is outside REQ.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_r <= '0;
    end else if (state_r != REQ) begin
      cnt_r <= '0;
    end else if (!mem_ack) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The last allowed REQ cycle is the one where the count reaches TIMEOUT_CYCLES-1.
  assign timeout_s = (state_r == REQ) && !mem_ack &&
                     (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No timeout in this build; the parameter has no effect here.
  assign timeout_s = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and next-output decode; ack takes priority over timeout.
  always_comb begin
    state_nxt_s = state_r;
    we_nxt_s    = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (read) begin
          state_nxt_s = REQ;
          we_nxt_s    = 1'b0;
        end else if (write) begin
          state_nxt_s = REQ;
          we_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_nxt_s = DONE;
        end else if (timeout_s) begin
          state_nxt_s = IDLE;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = REQ;
          we_nxt_s    = we_r;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered handshake outputs, all decoded from the next state.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      we_r    <= we_nxt_s;
      req_r   <= (state_nxt_s == REQ);
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
      err_r   <= err_nxt_s;
    end
  end

  assign mem_req    = req_r;
  assign mem_we     = we_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign idle       = (state_r == IDLE);
  assign rd_capture = (state_r == REQ) && mem_ack && !we_r;

endmodule

// File: rtl/mdr_mem_interface.sv
// Memory-side neighbour of the datapath bus: holds MAR and MDR and drives the
// memory handshake through mem_handshake_fsm.
// Optional macro: MEM_TIMEOUT_EN (REQ aborts after TIMEOUT_CYCLES cycles without ack).
// Ports:
//   clock, clear         : rising-edge clock, asynchronous active-low reset
//   BusMuxOut            : datapath bus value
//   MARin / MDRin        : load MAR (low ADDR_W bits) / MDR from the bus, only in IDLE
//   Read / Write         : start a transaction, only in IDLE; Read wins
//   mem_addr, mem_wdata  : MAR and MDR towards memory
//   mem_req, mem_we      : request and direction
//   mem_rdata, mem_ack   : read data and completion from memory
//   MDRout_q             : MDR contents towards the bus
//   busy, done, err      : transaction status
module mdr_mem_interface
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] MDRout_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] mdr_r;
  logic              idle_s;
  logic              rd_capture_s;

  mem_handshake_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clock      (clock),
    .clear      (clear),
    .read       (Read),
    .write      (Write),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .idle       (idle_s),
    .rd_capture (rd_capture_s)
  );

  // MAR: bus address load, frozen while a transaction is in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mar_r <= '0;
    end else if (idle_s && MARin) begin
      mar_r <= BusMuxOut[ADDR_W-1:0];
    end else begin
      mar_r <= mar_r;
    end
  end

  // MDR: read data from memory, or bus load while idle.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mdr_r <= '0;
    end else if (rd_capture_s) begin
      mdr_r <= mem_rdata;
    end else if (idle_s && MDRin) begin
      mdr_r <= BusMuxOut;
    end else begin
      mdr_r <= mdr_r;
    end
  end

  assign mem_addr  = mar_r;
  assign mem_wdata = mdr_r;
  assign MDRout_q  = mdr_r;

endmodule
